// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU core control path.
// Holds opcode encodings, sequencer state encodings, ALU op codes and
// small decode helpers used by the sequencer.
package cpu_pkg;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned ALU_W = 4;
   localparam int unsigned ST_W  = 3;

   // Opcode map
   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
   localparam logic [OP_W-1:0] OP_AND  = 4'h3;
   localparam logic [OP_W-1:0] OP_OR   = 4'h4;
   localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
   localparam logic [OP_W-1:0] OP_ADDI = 4'h6;
   localparam logic [OP_W-1:0] OP_LD   = 4'h7;
   localparam logic [OP_W-1:0] OP_ST   = 4'h8;
   localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
   localparam logic [OP_W-1:0] OP_BEQZ = 4'hA;
   localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

   // ALU operation codes
   localparam logic [ALU_W-1:0] ALU_NOP = 4'd0;
   localparam logic [ALU_W-1:0] ALU_ADD = 4'd1;
   localparam logic [ALU_W-1:0] ALU_SUB = 4'd2;
   localparam logic [ALU_W-1:0] ALU_AND = 4'd3;
   localparam logic [ALU_W-1:0] ALU_OR  = 4'd4;
   localparam logic [ALU_W-1:0] ALU_XOR = 4'd5;

   // Sequencer states; encoding is visible on state_dbg
   typedef enum logic [ST_W-1:0] {
      S_IDLE      = 3'd0,
      S_FETCH_LO  = 3'd1,
      S_FETCH_HI  = 3'd2,
      S_DECODE    = 3'd3,
      S_EXECUTE   = 3'd4,
      S_MEM       = 3'd5,
      S_WRITEBACK = 3'd6,
      S_HALT      = 3'd7
   } state_t;

   // ALU code driven while an instruction is in EXECUTE/MEM/WRITEBACK
   function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] op);
      logic [ALU_W-1:0] code;
      code = ALU_NOP;
      case (op)
         OP_ADD:  code = ALU_ADD;
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         OP_XOR:  code = ALU_XOR;
         OP_ADDI: code = ALU_ADD;
         OP_LD:   code = ALU_ADD;
         OP_ST:   code = ALU_ADD;
         OP_BEQZ: code = ALU_SUB;
         default: code = ALU_NOP;
      endcase
      return code;
   endfunction

   // Opcodes B..E are unassigned
   function automatic logic is_illegal(input logic [OP_W-1:0] op);
      return (op >= 4'hB) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/ack_timeout_counter.sv
// Memory-acknowledge watchdog counter.
// Ports: clk, rst (async active-low), clear (sync zero), enable (count up),
// expired (count has reached ACK_TIMEOUT-1).
module ack_timeout_counter #(
   parameter int unsigned ACK_TIMEOUT = 8,
   parameter int unsigned CNT_W       = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (ACK_TIMEOUT < 2) begin : g_bad_timeout
         $error("ack_timeout_counter: ACK_TIMEOUT must be >= 2");
      end
      if ((2 ** CNT_W) <= ACK_TIMEOUT) begin : g_bad_width
         $error("ack_timeout_counter: CNT_W too narrow for ACK_TIMEOUT");
      end
   endgenerate

   logic [CNT_W-1:0] count_q;

   // Clear has priority so a fresh request always starts from zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expired = (count_q == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU core.
// Fetches a 16-bit instruction as two bytes over a req/ack handshake, then
// sequences decode, execute, memory access and register writeback.
// Ports:
//   clk, rst (async active-low), run (continue at instruction boundary)
//   opcode, zero_flag     : from decoder / ALU
//   mem_ack               : memory handshake acknowledge
//   mem_req/read/write    : memory request and qualifiers (Moore)
//   ir_write_lo/hi        : IR byte load strobes
//   pc_en, jump_en        : PC increment / load-target strobes
//   reg_write, alu_op     : register file write strobe, ALU op code
//   halted, fault         : in HALT, sticky fault flag
//   state_dbg             : current state encoding
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 8,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [OP_W-1:0]  opcode,
   input  logic             zero_flag,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write_lo,
   output logic             ir_write_hi,
   output logic             pc_en,
   output logic             jump_en,
   output logic             reg_write,
   output logic [ALU_W-1:0] alu_op,
   output logic             halted,
   output logic             fault,
   output logic [ST_W-1:0]  state_dbg
);

   state_t          state_q;
   state_t          state_d;
   state_t          boundary;
   logic [OP_W-1:0] op_q;
   logic            fault_q;
   logic            fault_set;
   logic            wait_state;
   logic            tmo_clear;
   logic            tmo_en;
   logic            tmo_expired;

   // Counter restarts whenever a new state is entered; it only advances
   // while a request is outstanding without acknowledge.
   assign tmo_clear = (state_d != state_q);
   assign tmo_en    = wait_state & ~mem_ack;

   ack_timeout_counter #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_ack_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .enable  (tmo_en),
      .expired (tmo_expired)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Opcode is captured in DECODE and held until the instruction retires
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q    <= OP_NOP;
         fault_q <= 1'b0;
      end else begin
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
         if (fault_set) begin
            fault_q <= 1'b1;
         end
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      boundary    = run ? S_FETCH_LO : S_IDLE;
      fault_set   = 1'b0;
      wait_state  = 1'b0;
      mem_req     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write_lo = 1'b0;
      ir_write_hi = 1'b0;
      pc_en       = 1'b0;
      jump_en     = 1'b0;
      reg_write   = 1'b0;
      alu_op      = ALU_NOP;
      halted      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d = S_FETCH_LO;
            end
         end

         S_FETCH_LO: begin
            mem_req    = 1'b1;
            mem_read   = 1'b1;
            wait_state = 1'b1;
            if (mem_ack) begin
               ir_write_lo = 1'b1;
               pc_en       = 1'b1;
               state_d     = S_FETCH_HI;
            end else if (tmo_expired) begin
               fault_set = 1'b1;
               state_d   = S_HALT;
            end
         end

         S_FETCH_HI: begin
            mem_req    = 1'b1;
            mem_read   = 1'b1;
            wait_state = 1'b1;
            if (mem_ack) begin
               ir_write_hi = 1'b1;
               pc_en       = 1'b1;
               state_d     = S_DECODE;
            end else if (tmo_expired) begin
               fault_set = 1'b1;
               state_d   = S_HALT;
            end
         end

         S_DECODE: begin
            if (is_illegal(opcode)) begin
               fault_set = 1'b1;
               state_d   = S_HALT;
            end else if (opcode == OP_HLT) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXECUTE;
            end
         end

         S_EXECUTE: begin
            alu_op = alu_code(op_q);
            case (op_q)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
                  state_d = S_WRITEBACK;
               end
               OP_LD, OP_ST: begin
                  state_d = S_MEM;
               end
               OP_JMP: begin
                  pc_en   = 1'b1;
                  jump_en = 1'b1;
                  state_d = boundary;
               end
               OP_BEQZ: begin
                  pc_en   = zero_flag;
                  jump_en = zero_flag;
                  state_d = boundary;
               end
               default: begin
                  state_d = boundary;
               end
            endcase
         end

         S_MEM: begin
            mem_req    = 1'b1;
            mem_read   = (op_q == OP_LD);
            mem_write  = (op_q == OP_ST);
            alu_op     = alu_code(op_q);
            wait_state = 1'b1;
            if (mem_ack) begin
               state_d = (op_q == OP_LD) ? S_WRITEBACK : boundary;
            end else if (tmo_expired) begin
               fault_set = 1'b1;
               state_d   = S_HALT;
            end
         end

         S_WRITEBACK: begin
            reg_write = 1'b1;
            alu_op    = alu_code(op_q);
            state_d   = boundary;
         end

         S_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign fault     = fault_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of single instructions
// scored through an expectation queue, plus hand-written corner sequences.
module tb_cpu_sequencer;

   logic       clk;
   logic       rst;
   logic       run;
   logic [3:0] opcode;
   logic       zero_flag;
   logic       mem_ack;
   logic       mem_req;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write_lo;
   logic       ir_write_hi;
   logic       pc_en;
   logic       jump_en;
   logic       reg_write;
   logic [3:0] alu_op;
   logic       halted;
   logic       fault;
   logic [2:0] state_dbg;

   cpu_sequencer #(
      .ACK_TIMEOUT (8),
      .CNT_W       (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .opcode      (opcode),
      .zero_flag   (zero_flag),
      .mem_ack     (mem_ack),
      .mem_req     (mem_req),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .ir_write_lo (ir_write_lo),
      .ir_write_hi (ir_write_hi),
      .pc_en       (pc_en),
      .jump_en     (jump_en),
      .reg_write   (reg_write),
      .alu_op      (alu_op),
      .halted      (halted),
      .fault       (fault),
      .state_dbg   (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic       zf;
      int         fw;      // extra wait cycles before each fetch ack
      int         mw;      // extra wait cycles before the MEM ack
      int         cyc;     // cycles from FETCH_LO to boundary/HALT
      int         req;
      int         rd;
      int         wr;
      int         pc;
      int         jmp;
      int         rw;
      int         lo;
      int         hi;
      int         wbalu;   // alu_op seen during reg_write (0 if none)
      int         hlt;
      int         flt;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_checks;
   int   n_fail;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] op, input logic zf, input int fw, input int mw,
                      input int cyc, input int req, input int rd, input int wr,
                      input int pc, input int jmp, input int rw, input int lo,
                      input int hi, input int wbalu, input int hlt, input int flt);
      vec_t v;
      v.op = op; v.zf = zf; v.fw = fw; v.mw = mw; v.cyc = cyc; v.req = req;
      v.rd = rd; v.wr = wr; v.pc = pc; v.jmp = jmp; v.rw = rw; v.lo = lo;
      v.hi = hi; v.wbalu = wbalu; v.hlt = hlt; v.flt = flt;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      run = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Run one instruction from IDLE with a simple wait-state memory model
   task automatic run_vec(input int idx, input vec_t v);
      vec_t e;
      int   cyc, req, rd, wr, pc, jmp, rw, lo, hi, wbalu, req_cnt, wt;
      bit   done;
      int   h, f;
      string p;
      exp_q.push_back(v);
      cyc = 0; req = 0; rd = 0; wr = 0; pc = 0; jmp = 0; rw = 0; lo = 0; hi = 0;
      wbalu = 0; req_cnt = 0; done = 0; h = 0; f = 0;
      @(negedge clk);
      opcode = v.op;
      zero_flag = v.zf;
      mem_ack = 1'b0;
      run = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         run = 1'b0;
         wt = (state_dbg == 3'd5) ? v.mw : v.fw;
         mem_ack = mem_req && (req_cnt >= wt);
         #1;
         if (state_dbg == 3'd0 || state_dbg == 3'd7) begin
            done = 1;
            h = int'(halted);
            f = int'(fault);
            break;
         end
         cyc++;
         if (mem_req)     req++;
         if (mem_read)    rd++;
         if (mem_write)   wr++;
         if (pc_en)       pc++;
         if (jump_en)     jmp++;
         if (ir_write_lo) lo++;
         if (ir_write_hi) hi++;
         if (reg_write) begin
            rw++;
            wbalu = int'(alu_op);
         end
         if (mem_req && !mem_ack) req_cnt++;
         else req_cnt = 0;
      end
      mem_ack = 1'b0;
      e = exp_q.pop_front();
      p = $sformatf("vec%0d_op%0h", idx, e.op);
      chk({p, "_done"},  int'(done), 1);
      chk({p, "_cyc"},   cyc,   e.cyc);
      chk({p, "_req"},   req,   e.req);
      chk({p, "_rd"},    rd,    e.rd);
      chk({p, "_wr"},    wr,    e.wr);
      chk({p, "_pc"},    pc,    e.pc);
      chk({p, "_jmp"},   jmp,   e.jmp);
      chk({p, "_rw"},    rw,    e.rw);
      chk({p, "_irlo"},  lo,    e.lo);
      chk({p, "_irhi"},  hi,    e.hi);
      chk({p, "_wbalu"}, wbalu, e.wbalu);
      chk({p, "_halt"},  h,     e.hlt);
      chk({p, "_fault"}, f,     e.flt);
      if (e.hlt != 0) begin
         // HALT must hold with run asserted until reset
         run = 1'b1;
         repeat (3) @(negedge clk);
         #1;
         chk({p, "_halt_hold_st"}, int'(state_dbg), 7);
         chk({p, "_halt_hold_flt"}, int'(fault), e.flt);
         do_reset();
      end
   endtask

   int exp_st[7];
   int pcs;

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b0;
      run = 1'b0;
      opcode = 4'h0;
      zero_flag = 1'b0;
      mem_ack = 1'b0;

      // Reset state: every output low
      #2;
      chk("reset_outputs",
          int'({mem_req, mem_read, mem_write, ir_write_lo, ir_write_hi, pc_en,
                jump_en, reg_write, alu_op, halted, fault, state_dbg}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_after_reset", int'(state_dbg), 0);

      //   op    zf  fw mw cyc req rd wr pc jmp rw lo hi alu h f
      add(4'h1, 0, 0, 0,  5,  2, 2, 0, 2, 0, 1, 1, 1, 1, 0, 0);
      add(4'h2, 0, 1, 0,  7,  4, 4, 0, 2, 0, 1, 1, 1, 2, 0, 0);
      add(4'h3, 0, 0, 0,  5,  2, 2, 0, 2, 0, 1, 1, 1, 3, 0, 0);
      add(4'h4, 0, 0, 0,  5,  2, 2, 0, 2, 0, 1, 1, 1, 4, 0, 0);
      add(4'h5, 0, 2, 0,  9,  6, 6, 0, 2, 0, 1, 1, 1, 5, 0, 0);
      add(4'h6, 0, 0, 0,  5,  2, 2, 0, 2, 0, 1, 1, 1, 1, 0, 0);
      add(4'h7, 0, 0, 3,  9,  6, 6, 0, 2, 0, 1, 1, 1, 1, 0, 0);
      add(4'h8, 0, 0, 0,  5,  3, 2, 1, 2, 0, 0, 1, 1, 0, 0, 0);
      add(4'h8, 0, 1, 2,  9,  7, 4, 3, 2, 0, 0, 1, 1, 0, 0, 0);
      add(4'h9, 0, 0, 0,  4,  2, 2, 0, 3, 1, 0, 1, 1, 0, 0, 0);
      add(4'hA, 1, 0, 0,  4,  2, 2, 0, 3, 1, 0, 1, 1, 0, 0, 0);
      add(4'hA, 0, 0, 0,  4,  2, 2, 0, 2, 0, 0, 1, 1, 0, 0, 0);
      add(4'h0, 0, 0, 0,  4,  2, 2, 0, 2, 0, 0, 1, 1, 0, 0, 0);
      add(4'hC, 0, 0, 0,  3,  2, 2, 0, 2, 0, 0, 1, 1, 0, 1, 1);
      add(4'hF, 0, 0, 0,  3,  2, 2, 0, 2, 0, 0, 1, 1, 0, 1, 0);
      add(4'hB, 0, 0, 0,  3,  2, 2, 0, 2, 0, 0, 1, 1, 0, 1, 1);
      add(4'hE, 0, 0, 0,  3,  2, 2, 0, 2, 0, 0, 1, 1, 0, 1, 1);
      add(4'h1, 0, 7, 0, 19, 16,16, 0, 2, 0, 1, 1, 1, 1, 0, 0);
      add(4'h1, 0, 8, 0,  8,  8, 8, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      add(4'h7, 0, 0, 8, 12, 10,10, 0, 2, 0, 0, 1, 1, 0, 1, 1);
      add(4'h8, 0, 0, 8, 12, 10, 2, 8, 2, 0, 0, 1, 1, 0, 1, 1);

      foreach (tbl[i]) run_vec(i, tbl[i]);

      // Back-to-back ADD with zero-wait memory and run held high
      exp_st[1] = 1; exp_st[2] = 2; exp_st[3] = 3;
      exp_st[4] = 4; exp_st[5] = 6; exp_st[6] = 1;
      pcs = 0;
      @(negedge clk);
      opcode = 4'h1;
      mem_ack = 1'b1;
      run = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("b2b_state_c%0d", c), int'(state_dbg), exp_st[c]);
         if (c <= 5 && pc_en) pcs++;
         if (c == 1) chk("b2b_irlo_c1", int'(ir_write_lo), 1);
         if (c == 2) chk("b2b_irhi_c2", int'(ir_write_hi), 1);
         if (c == 5) begin
            chk("b2b_rw_c5", int'(reg_write), 1);
            chk("b2b_alu_c5", int'(alu_op), 1);
         end
      end
      chk("b2b_pc_en_count", pcs, 2);
      run = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (state_dbg == 3'd0) break;
      end
      chk("b2b_park_idle", int'(state_dbg), 0);
      mem_ack = 1'b0;

      // Asynchronous reset while ST is waiting in MEM
      @(negedge clk);
      opcode = 4'h8;
      run = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         run = 1'b0;
         mem_ack = mem_req && (state_dbg != 3'd5);
         #1;
         if (state_dbg == 3'd5) break;
      end
      chk("rstmem_reached_mem", int'(state_dbg), 5);
      chk("rstmem_req_before", int'(mem_req & mem_write), 1);
      #1;
      rst = 1'b0;
      #1;
      chk("rstmem_outputs_low",
          int'({mem_req, mem_read, mem_write, ir_write_lo, ir_write_hi, pc_en,
                jump_en, reg_write, alu_op, halted, fault, state_dbg}), 0);
      @(negedge clk);
      rst = 1'b1;
      run = 1'b0;
      mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rstmem_stays_idle", int'(state_dbg), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit CPU core.
- Fetches each 16-bit instruction as two bytes over a req/ack memory handshake and drives the IR byte strobes and PC increment/jump.
- Sequences execute, memory and writeback for the 4-bit opcode from the decoder.
- Sits between program/data memory, PC, instruction register, register file and ALU. It supersedes the inline Fetch always-block and the standalone control FSM.

Parameters:
- ACK_TIMEOUT, 8: maximum cycles a memory request waits for mem_ack before a fault halt. Must be >= 2.
- CNT_W, 4: width of the timeout counter. Must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  1 = keep executing; 0 = park in IDLE at the next instruction boundary.
- opcode  in  4  opcode field from the decoder (IR valid from DECODE onward).
- zero_flag  in  1  ALU result-is-zero, valid during EXECUTE.
- mem_ack  in  1  memory accepted or returned the byte this cycle.
- mem_req  out  1  memory request, held until ack.
- mem_read  out  1  read qualifier.
- mem_write  out  1  write qualifier.
- ir_write_lo  out  1  load the low IR byte (1-cycle strobe).
- ir_write_hi  out  1  load the high IR byte (1-cycle strobe).
- pc_en  out  1  PC update strobe (+1, or load target if jump_en).
- jump_en  out  1  PC loads next_pc_value instead of incrementing.
- reg_write  out  1  register file write strobe.
- alu_op  out  4  ALU operation code.
- halted  out  1  sequencer is in HALT.
- fault  out  1  sticky: halt caused by illegal opcode or ack timeout.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; timeout counter and fault clear.
  - All outputs are 0 while rst=0 and in IDLE.
- State encoding: IDLE=0, FETCH_LO=1, FETCH_HI=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- Output timing: state is registered. mem_req, mem_read, mem_write and alu_op are Moore outputs (state plus latched opcode). Strobes are combinational and qualified by mem_ack or zero_flag in the current cycle.
- Opcode map:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 ADDI
  - 7 LD, 8 ST
  - 9 JMP
  - A BEQZ
  - F HLT
  - B-E illegal.
- IDLE: if run=1, go to FETCH_LO; otherwise stay.
- FETCH_LO:
  - Drive mem_req=1, mem_read=1.
  - On mem_ack: ir_write_lo=1, pc_en=1 in the same cycle, then go to FETCH_HI.
- FETCH_HI: same as FETCH_LO but with ir_write_hi. On mem_ack, go to DECODE.
- DECODE:
  - One cycle, no strobes. The sequencer latches opcode internally; it is held to end of instruction.
  - Illegal opcode: HALT with fault=1.
  - HLT: HALT with fault=0.
  - Otherwise: EXECUTE.
- EXECUTE:
  - alu_op: 1-5 pass through; ADDI, LD, ST drive 1 (add); BEQZ drives 2 (sub); NOP and JMP drive 0.
  - ALU ops and ADDI: go to WRITEBACK.
  - LD and ST: go to MEM.
  - JMP: pc_en=1, jump_en=1.
  - BEQZ: pc_en=jump_en=zero_flag.
  - NOP, JMP, BEQZ: go to BOUNDARY.
- MEM:
  - mem_req=1; mem_read=1 for LD, mem_write=1 for ST; alu_op held at 1.
  - On mem_ack: LD goes to WRITEBACK, ST goes to BOUNDARY.
- WRITEBACK: reg_write=1 for exactly one cycle, alu_op held, then go to BOUNDARY.
- BOUNDARY (not a state; the next-state choice): run=1 goes to FETCH_LO, run=0 goes to IDLE. A run deassert mid-instruction completes that instruction.
- HALT: halted=1; all other strobes 0. Exit only by reset.
- Timeout:
  - The counter clears on entry to FETCH_LO, FETCH_HI and MEM, and increments each cycle in those states without ack.
  - If the counter equals ACK_TIMEOUT-1 and mem_ack=0: go to HALT, fault=1, no strobes.
  - An ack on that same cycle wins (no fault).
- Latency with zero-wait memory (ack in the first req cycle):
  - ALU op: 5 cycles.
  - LD: 6 cycles.
  - ST: 5 cycles.
  - JMP, BEQZ, NOP: 4 cycles, boundary to boundary.
- PC width (3-bit) and wrap 7→0 belong to the PC module. The sequencer issues exactly two pc_en per fetch regardless of the PC value.
- Reset mid-handshake: mem_req drops immediately (asynchronous); no strobe is emitted.

Decomposition:
- Shared package cpu_pkg: opcode localparams (OP_NOP…OP_HLT), state encodings (S_IDLE…S_HALT), ALU op codes (ALU_ADD=1, ALU_SUB=2, …).
- One sub-module, ack_timeout_counter: clear, enable, asynchronous active-low reset; outputs expired at ACK_TIMEOUT-1.

Test Plan:
- Reset then run=1, opcode=1 (ADD), mem_ack tied 1 → ir_write_lo at cycle 1, ir_write_hi at cycle 2, reg_write at cycle 5 with alu_op=1; exactly two pc_en; FETCH_LO re-entered at cycle 6.
- LD (opcode 7) with ack delayed 3 cycles in MEM → mem_req and mem_read held for 4 cycles, then reg_write for 1 cycle; no fault.
- BEQZ with zero_flag=1, then again with zero_flag=0 → first: pc_en=jump_en=1 in EXECUTE; second: both 0; state_dbg 4→1 in both cases.
- Illegal opcode 0xC, then HLT 0xF (after reset) → halted=1, state_dbg=7; fault=1 for the first case, fault=0 for the second; stays halted with run=1 until rst=0.
- mem_ack held 0 in FETCH_LO with ACK_TIMEOUT=8 → HALT with fault=1 on the 8th request cycle, no ir_write. Repeat with ack on the 8th cycle → no fault.
- Assert rst=0 during MEM of ST → all outputs 0 immediately, state_dbg=0; after release with run=0, stays IDLE.
